// File: rtl/dmem_line_ctrl.sv
// Line-wide data memory with valid/ready request port and fixed-latency response.
// Optional DMEM_RANGE_CHECK_EN adds rsp_err and blocks out-of-range accesses.
module dmem_line_ctrl #(
  parameter int unsigned ADDR_SIZE   = 32,
  parameter int unsigned LINE_BYTES  = 16,
  parameter int unsigned DEPTH_LINES = 32,
  parameter int unsigned LATENCY     = 5
) (
  input  logic                    clk,
  input  logic                    reset_n,
  input  logic                    req_valid,
  output logic                    req_ready,
  input  logic                    req_wr,
  input  logic [ADDR_SIZE-1:0]    req_addr,
  input  logic [LINE_BYTES*8-1:0] req_wdata,
  input  logic [LINE_BYTES-1:0]   req_be,
  output logic                    rsp_valid,
  output logic [LINE_BYTES*8-1:0] rsp_rdata
`ifdef DMEM_RANGE_CHECK_EN
  ,
  output logic                    rsp_err
`endif
);

  localparam int unsigned OFF_W = $clog2(LINE_BYTES);
  localparam int unsigned IDX_W = $clog2(DEPTH_LINES);
  localparam int unsigned LW    = LINE_BYTES * 8;
  localparam logic [7:0]  CNT_INIT = 8'(LATENCY - 1);

  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

  state_t                r_state, w_state_nxt;
  logic [7:0]            r_cnt, w_cnt_nxt;
  logic                  r_wr, r_oor, r_err;
  logic [IDX_W-1:0]      r_idx;
  logic [LW-1:0]         r_wdata, r_rdata;
  logic [LINE_BYTES-1:0] r_be;
  logic [LW-1:0]         r_mem [DEPTH_LINES];

  logic                  w_accept, w_commit, w_req_oor;
  logic                  w_c_wr, w_c_oor;
  logic [IDX_W-1:0]      w_c_idx;
  logic [LW-1:0]         w_c_wdata;
  logic [LINE_BYTES-1:0] w_c_be;
  logic                  w_unused;

  assign w_unused = ^req_addr;

`ifdef DMEM_RANGE_CHECK_EN
  localparam logic [ADDR_SIZE:0] LIMIT = (ADDR_SIZE+1)'(DEPTH_LINES * LINE_BYTES);
  assign w_req_oor = ({1'b0, req_addr} >= LIMIT);
  assign rsp_err   = r_err;
`else
  assign w_req_oor = 1'b0;
`endif

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    req_ready   = 1'b0;
    rsp_valid   = 1'b0;
    w_accept    = 1'b0;
    w_commit    = 1'b0;
    case (r_state)
      IDLE: begin
        req_ready = 1'b1;
        if (req_valid) begin
          w_accept  = 1'b1;
          w_cnt_nxt = CNT_INIT;
          if (LATENCY == 1) begin
            w_state_nxt = RESP;
            w_commit    = 1'b1;
          end else begin
            w_state_nxt = WAIT;
          end
        end
      end
      WAIT: begin
        w_cnt_nxt = r_cnt - 8'd1;
        if (r_cnt <= 8'd1) begin
          w_state_nxt = RESP;
          w_commit    = 1'b1;
        end
      end
      RESP: begin
        rsp_valid   = 1'b1;
        w_state_nxt = IDLE;
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  // With LATENCY=1 the commit edge is also the acceptance edge, so use the live request.
  always_comb begin
    w_c_wr    = r_wr;
    w_c_oor   = r_oor;
    w_c_idx   = r_idx;
    w_c_wdata = r_wdata;
    w_c_be    = r_be;
    if (r_state == IDLE) begin
      w_c_wr    = req_wr;
      w_c_oor   = w_req_oor;
      w_c_idx   = req_addr[OFF_W +: IDX_W];
      w_c_wdata = req_wdata;
      w_c_be    = req_be;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= IDLE;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_wr    <= 1'b0;
      r_oor   <= 1'b0;
      r_idx   <= '0;
      r_wdata <= '0;
      r_be    <= '0;
    end else if (w_accept) begin
      r_wr    <= req_wr;
      r_oor   <= w_req_oor;
      r_idx   <= req_addr[OFF_W +: IDX_W];
      r_wdata <= req_wdata;
      r_be    <= req_be;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int unsigned i = 0; i < DEPTH_LINES; i++) begin
        r_mem[IDX_W'(i)] <= '0;
      end
      r_rdata <= '0;
      r_err   <= 1'b0;
    end else if (w_commit) begin
      r_err <= w_c_oor;
      if (w_c_wr) begin
        r_rdata <= '0;
        if (!w_c_oor) begin
          for (int unsigned b = 0; b < LINE_BYTES; b++) begin
            if (w_c_be[b]) begin
              r_mem[w_c_idx][8*b +: 8] <= w_c_wdata[8*b +: 8];
            end
          end
        end
      end else begin
        r_rdata <= w_c_oor ? '0 : r_mem[w_c_idx];
      end
    end
  end

  assign rsp_rdata = r_rdata;

endmodule
